// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin barrel-thread issue selector with per-thread PC, halt and in-flight tracking
module thread_scheduler #(
  parameter int NUM_THREADS = 4,
  parameter int TID_WIDTH = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_OFFSET = 'h100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_THREADS-1:0]   thread_en,
  input  logic [NUM_THREADS-1:0]   stall,
  input  logic                     issue_ready,
  output logic                     issue_valid,
  output logic [TID_WIDTH-1:0]     issue_tid,
  output logic [ADDRESS_WIDTH-1:0] issue_pc,
  input  logic                     retire_valid,
  input  logic [TID_WIDTH-1:0]     retire_tid,
  input  logic                     retire_redirect,
  input  logic [ADDRESS_WIDTH-1:0] retire_pc,
  input  logic                     retire_halt,
  output logic [NUM_THREADS-1:0]   active,
  output logic                     all_halted
);
  logic [ADDRESS_WIDTH-1:0] pc [NUM_THREADS];
  logic [NUM_THREADS-1:0] inflight, eligible;
  logic [TID_WIDTH-1:0] last_tid, sel, idx;
  logic fire;
  assign eligible = thread_en & active & ~inflight & ~stall;
  assign issue_valid = |eligible;
  assign issue_tid = issue_valid ? sel : '0;
  assign issue_pc = issue_valid ? pc[sel] : '0;
  assign fire = issue_valid & issue_ready;
  assign all_halted = ~|active;
  // scan from the thread after last_tid backwards so the nearest eligible thread wins
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      idx = TID_WIDTH'((int'(last_tid) + k) % NUM_THREADS);
      sel = eligible[idx] ? idx : sel;
    end
  end
  // retire and issue never touch the same thread in one cycle, since inflight blocks issue
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) pc[t] <= RESET_PC + ADDRESS_WIDTH'(t) * THREAD_PC_OFFSET;
      active <= '1;
      inflight <= '0;
      last_tid <= TID_WIDTH'(NUM_THREADS - 1);
    end else begin
      if (retire_valid && inflight[retire_tid]) begin
        inflight[retire_tid] <= 1'b0;
        if (retire_redirect) pc[retire_tid] <= retire_pc;
        if (retire_halt) active[retire_tid] <= 1'b0;
      end
      if (fire) begin
        inflight[sel] <= 1'b1;
        pc[sel] <= pc[sel] + ADDRESS_WIDTH'(4);
        last_tid <= sel;
      end
    end
  end
endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: directed and random checks of thread_scheduler against a behavioural model
module tb_thread_scheduler;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  logic [3:0] thread_en = '1, stall = '0;
  logic issue_ready = 0, retire_valid = 0, retire_redirect = 0, retire_halt = 0;
  logic [1:0] retire_tid = '0;
  logic [31:0] retire_pc = '0;
  logic issue_valid, all_halted;
  logic [1:0] issue_tid;
  logic [31:0] issue_pc;
  logic [3:0] active;
  int total = 0, bad = 0;
  logic [31:0] m_pc [N];
  bit m_act [N];
  bit m_inf [N];
  int m_last;

  always #5 clk = ~clk;

  thread_scheduler dut (
    .clk(clk), .rst(rst), .thread_en(thread_en), .stall(stall), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_pc(issue_pc),
    .retire_valid(retire_valid), .retire_tid(retire_tid), .retire_redirect(retire_redirect),
    .retire_pc(retire_pc), .retire_halt(retire_halt), .active(active), .all_halted(all_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < N; t++) begin
      m_pc[t] = 32'(t) * 32'h100;
      m_act[t] = 1;
      m_inf[t] = 0;
    end
    m_last = N - 1;
  endtask

  task automatic expect_issue(output bit v, output int tid);
    v = 0;
    tid = 0;
    for (int k = 1; k <= N; k++) begin
      int t;
      t = (m_last + k) % N;
      if (!v && thread_en[t] && m_act[t] && !m_inf[t] && !stall[t]) begin
        v = 1;
        tid = t;
      end
    end
  endtask

  task automatic set(input logic [3:0] en, input logic [3:0] st, input logic rdy, input logic rv,
                     input logic [1:0] rt, input logic rr, input logic [31:0] rp, input logic rh);
    thread_en = en; stall = st; issue_ready = rdy; retire_valid = rv;
    retire_tid = rt; retire_redirect = rr; retire_pc = rp; retire_halt = rh;
  endtask

  // check outputs against the model, then advance one clock applying the same rules to the model
  task automatic step();
    bit v;
    int tid;
    logic [3:0] a;
    #1;
    expect_issue(v, tid);
    for (int t = 0; t < N; t++) a[t] = m_act[t];
    chk("issue_valid", 32'(issue_valid), 32'(v));
    chk("issue_tid", 32'(issue_tid), v ? tid : 0);
    chk("issue_pc", issue_pc, v ? m_pc[tid] : 32'h0);
    chk("active", 32'(active), 32'(a));
    chk("all_halted", 32'(all_halted), 32'(a == 4'h0));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (retire_valid && m_inf[retire_tid]) begin
        m_inf[retire_tid] = 0;
        if (retire_redirect) m_pc[retire_tid] = retire_pc;
        if (retire_halt) m_act[retire_tid] = 0;
      end
      if (v && issue_ready) begin
        m_inf[tid] = 1;
        m_pc[tid] = m_pc[tid] + 32'd4;
        m_last = tid;
      end
    end
    #1;
  endtask

  task automatic chk_reset_outputs();
    #1;
    chk("rst_valid", 32'(issue_valid), 1);
    chk("rst_tid", 32'(issue_tid), 0);
    chk("rst_pc", issue_pc, 32'h0);
    chk("rst_active", 32'(active), 32'hF);
    chk("rst_all_halted", 32'(all_halted), 0);
  endtask

  initial begin
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    chk_reset_outputs();
    for (int i = 0; i < 4; i++) begin
      set(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
      #1;
      chk("seq_tid", 32'(issue_tid), i);
      chk("seq_pc", issue_pc, 32'(i) * 32'h100);
      step();
    end
    #1;
    chk("drained_valid", 32'(issue_valid), 0);
    set(4'hF, 4'h0, 1, 1, 1, 0, 0, 0);
    step();
    set(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("reissue_tid", 32'(issue_tid), 1);
    chk("reissue_pc", issue_pc, 32'h104);
    step();
    set(4'hF, 4'h0, 1, 1, 2, 1, 32'h480, 0);
    step();
    set(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("redirect_pc", issue_pc, 32'h480);
    step();
    set(4'hF, 4'h0, 1, 1, 2, 0, 0, 0);
    step();
    set(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("redirect_next_pc", issue_pc, 32'h484);
    step();
    rst = 1;
    set(4'hF, 4'b0010, 1, 0, 0, 0, 0, 0);
    step();
    rst = 0;
    #1; chk("stall_tid0", 32'(issue_tid), 0); step();
    #1; chk("stall_tid2", 32'(issue_tid), 2); step();
    #1; chk("stall_tid3", 32'(issue_tid), 3); step();
    set(4'hF, 4'b0010, 1, 1, 0, 0, 0, 0);
    #1; chk("stall_none", 32'(issue_valid), 0); step();
    set(4'hF, 4'b0010, 1, 0, 0, 0, 0, 0);
    #1; chk("stall_tid0_again", 32'(issue_tid), 0); step();
    set(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("unstall_tid1", 32'(issue_tid), 1);
    chk("unstall_pc1", issue_pc, 32'h100);
    step();
    rst = 1;
    set(4'hF, 4'h0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      set(4'hF, 4'h0, 0, 1, 3, 1, 32'h40, 1);
      #1;
      chk("hold_tid", 32'(issue_tid), 0);
      chk("hold_pc", issue_pc, 32'h0);
      step();
    end
    set(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("hold_pc_after", issue_pc, 32'h0);
    chk("ignored_retire_active", 32'(active), 32'hF);
    step();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) step();
    for (int t = 0; t < 4; t++) begin
      logic [3:0] e;
      e = 4'hF << (t + 1);
      set(4'hF, 4'h0, 1, 1, 2'(t), 0, 0, 1);
      step();
      chk("halt_active", 32'(active), 32'(e));
    end
    set(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("halted_all", 32'(all_halted), 1);
    chk("halted_valid", 32'(issue_valid), 0);
    rst = 1;
    step();
    rst = 0;
    chk_reset_outputs();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      thread_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      stall = 4'($urandom) & 4'($urandom);
      issue_ready = ($urandom_range(0, 3) != 0);
      retire_valid = 1'($urandom_range(0, 1));
      retire_tid = 2'($urandom);
      retire_redirect = ($urandom_range(0, 3) == 0);
      retire_pc = $urandom & ~32'h3;
      retire_halt = ($urandom_range(0, 29) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
